blackparrot_fpga_host_io_out: RTL
=================================

# blackparrot_fpga_host_io_out

AXI4 subordinate that accepts BlackParrot I/O-out write transactions (putchar, finish, host-bound stores) and serializes each write into an NBF-format packet of 32-bit flits toward the host FIFO. It is the BP-to-host counterpart of the host NBF loader, which carries host-to-BP traffic. Reads are acknowledged with zero data so BP never hangs on a stray host access.

## Interface
- S_AXI_ADDR_WIDTH, 64: AXI address width; must be 64.
- S_AXI_DATA_WIDTH, 64: AXI data width; must be 64.
- S_AXI_ID_WIDTH, 4: AXI ID width.
- fifo_data_width_p, 32: host flit width; must be 32.
- nbf_opcode_width_p, 8: packet opcode width.
- nbf_addr_width_p, 64: packet address width; must be 64.
- nbf_data_width_p, 64: packet data width; must be 64.

Ports:
- s_axi_aclk  in  1  single clock for the block.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- AW channel: s_axi_awaddr in ADDR, awvalid in 1, awready out 1, awid in ID, awlen in 8, awsize in 3, awburst in 2; awlock/awcache/awprot/awqos/awregion are inputs and are ignored.
- W channel: s_axi_wdata in DATA, wstrb in DATA/8 (ignored), wvalid in 1, wlast in 1, wready out 1.
- B channel: s_axi_bvalid out 1, bready in 1, bid out ID, bresp out 2.
- AR channel: s_axi_araddr in ADDR, arvalid in 1, arready out 1, arid in ID, arlen in 8, arsize in 3; other AR sideband inputs are ignored.
- R channel: s_axi_rdata out DATA, rvalid out 1, rready in 1, rid out ID, rlast out 1, rresp out 2.
- io_v_o  out  1  flit valid to host FIFO.
- io_data_o  out  32  flit data.
- io_ready_and_i  in  1  host FIFO ready; a flit transfers when io_v_o & io_ready_and_i.

## Operation
- Packet format: {opcode[7:0], addr[63:0], data[63:0]} (136 b), zero-padded to 160 b and sent as 5 flits, bits [31:0] first. Flit 4 carries the opcode in bits [7:0], with bits [31:8] = 0.
- Opcode is selected by awsize: 0 → 8'h0, 1 → 8'h1, 2 → 8'h2, 3 → 8'h3.
- The addr field is awaddr unmodified.
- The data field is wdata >> (8·awaddr[2:0]), then masked to the low 2^awsize bytes with upper bits zeroed. wstrb is not used.
- Write FSM states: W_IDLE, W_DATA, W_SEND, W_RESP.
  - W_IDLE: awready=1. On AW handshake, capture addr, id, size and len, then go to W_DATA.
  - W_DATA: wready=1. Only the first beat's data is captured; remaining beats are consumed. On the beat with wlast=1, go to W_SEND.
  - W_SEND: io_v_o=1 and io_data_o = current flit. The flit counter (0–4) advances on each transfer. After flit 4 transfers, go to W_RESP.
  - W_RESP: bvalid=1 and bid = captured id. bresp = 2'b00 if len==0, otherwise 2'b10 (SLVERR: bursts unsupported). On B handshake, go to W_IDLE.
- wready is never asserted before the AW handshake. A W beat arriving first waits.
- Read FSM is independent of the write FSM and may run concurrently. States: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, capture arid and load the beat counter with arlen.
  - R_DATA: rvalid=1, rdata=0, rresp=2'b00, rid = captured id, rlast = (counter==0). On each R handshake the counter decrements. The handshake with rlast=1 returns to R_IDLE.
- Reset values: all ready/valid outputs 0, bid/bresp/rid/rresp/rlast/rdata/io_data_o 0, both FSMs in IDLE, flit counter 0. awready and arready rise on the first clock edge after reset deasserts.
- Reset asserted mid-operation clears all state asynchronously. A partial packet is discarded and io_v_o drops immediately; it is not resumed.

## Timing
- Minimum write latency: AW handshake at cycle N; wready at N+1; W handshake at N+1; flits 0–4 at N+2..N+6 with io_ready_and_i held high; bvalid at N+7. Next awready comes one cycle after the B handshake, so each write occupies 8 cycles minimum.
- io_data_o and io_v_o are held stable while io_v_o & ~io_ready_and_i; flits never reorder or repeat.
- bvalid and rvalid, once asserted, stay high with stable payload until handshake.
- Minimum read latency: AR handshake at cycle N; first rvalid at N+1; one beat per cycle while rready is high.
- All outputs are registered or derived from FSM state only. There is no combinational path from any valid input to any ready output.

## Test plan
- 64-bit write, awaddr=0x0010_1000, wdata=0x1122334455667788, awsize=3 → flits 0x55667788, 0x11223344, 0x00101000, 0x00000000, 0x00000003; then bresp=0 with bid = awid.
- 32-bit write at awaddr=0x...1004, wdata=0xAABBCCDD_00000000, awsize=2 → data field 0x00000000AABBCCDD; flit 0 = 0xAABBCCDD; flit 4 = 0x00000002.
- Host backpressure: io_ready_and_i toggles randomly during W_SEND → all 5 flits transfer exactly once, in order, with values stable while stalled; bvalid is only asserted after flit 4.
- Burst write, awlen=3, wdata beats 1..4 → 4 beats accepted; one packet carrying data 1; bresp=2'b10.
- Read, arlen=2, arid=5, with rready stalled one cycle → 3 beats of rdata=0, rid=5, rlast only on the third beat. A concurrent write completes unaffected.
- s_axi_aresetn asserted after flit 2 → io_v_o=0 immediately. After release, a new write emits a complete 5-flit packet starting at flit 0.

Source files
------------

// File: rtl/blackparrot_fpga_host_io_out.sv
// BlackParrot I/O-out AXI4 subordinate: serializes each write into a
// 5-flit NBF packet for the host FIFO; reads return zero data.
module blackparrot_fpga_host_io_out #(
  parameter int S_AXI_ADDR_WIDTH   = 64,
  parameter int S_AXI_DATA_WIDTH   = 64,
  parameter int S_AXI_ID_WIDTH     = 4,
  parameter int fifo_data_width_p  = 32,
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 64,
  parameter int nbf_data_width_p   = 64
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awlock,
  input  logic [3:0]                    s_axi_awcache,
  input  logic [2:0]                    s_axi_awprot,
  input  logic [3:0]                    s_axi_awqos,
  input  logic [3:0]                    s_axi_awregion,
  input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  input  logic                          s_axi_wlast,
  output logic                          s_axi_wready,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arlock,
  input  logic [3:0]                    s_axi_arcache,
  input  logic [2:0]                    s_axi_arprot,
  input  logic [3:0]                    s_axi_arqos,
  input  logic [3:0]                    s_axi_arregion,
  output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic                          s_axi_rlast,
  output logic [1:0]                    s_axi_rresp,
  output logic                          io_v_o,
  output logic [fifo_data_width_p-1:0]  io_data_o,
  input  logic                          io_ready_and_i
);

  localparam int pkt_w =
    nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int flits_lp =
    (pkt_w + fifo_data_width_p - 1) / fifo_data_width_p;
  localparam int pad_w = flits_lp * fifo_data_width_p;
  localparam logic [2:0] last_flit = 3'(flits_lp - 1);

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_SEND, W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } r_state_e;

  w_state_e w_state;
  r_state_e r_state;

  logic [S_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [S_AXI_ID_WIDTH-1:0]     wid_q;
  logic [2:0]                    size_q;
  logic [7:0]                    len_q;
  logic [nbf_data_width_p-1:0]   data_q;
  logic                          first_q;
  logic [2:0]                    flit_q;
  logic [7:0]                    rcnt_q;

  logic [nbf_data_width_p-1:0]   shifted;
  logic [nbf_data_width_p-1:0]   masked;
  logic [nbf_data_width_p-1:0]   data_sel;
  logic [nbf_opcode_width_p-1:0] opcode;
  logic [pad_w-1:0]              pkt;
  logic [2:0]                    nxt_flit;
  logic [fifo_data_width_p-1:0]  flit_word;

  // Data field is the beat right-justified to the access size.
  always_comb begin
    shifted = s_axi_wdata >> {addr_q[2:0], 3'b000};
    masked  = shifted;
    opcode  = nbf_opcode_width_p'(3);
    unique case (size_q)
      3'd0: begin
        masked = {56'b0, shifted[7:0]};
        opcode = nbf_opcode_width_p'(0);
      end
      3'd1: begin
        masked = {48'b0, shifted[15:0]};
        opcode = nbf_opcode_width_p'(1);
      end
      3'd2: begin
        masked = {32'b0, shifted[31:0]};
        opcode = nbf_opcode_width_p'(2);
      end
      default: ;
    endcase
    data_sel  = first_q ? masked : data_q;
    pkt       = pad_w'({opcode, addr_q, data_sel});
    nxt_flit  = 3'd0;
    if (w_state == W_SEND && flit_q != last_flit)
      nxt_flit = flit_q + 3'd1;
    flit_word =
      pkt[fifo_data_width_p*int'(nxt_flit) +: fifo_data_width_p];
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      io_v_o        <= 1'b0;
      io_data_o     <= '0;
      addr_q        <= '0;
      wid_q         <= '0;
      size_q        <= '0;
      len_q         <= '0;
      data_q        <= '0;
      first_q       <= 1'b0;
      flit_q        <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            addr_q        <= s_axi_awaddr;
            wid_q         <= s_axi_awid;
            size_q        <= s_axi_awsize;
            len_q         <= s_axi_awlen;
            first_q       <= 1'b1;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid && s_axi_wready) begin
            first_q <= 1'b0;
            if (first_q) data_q <= masked;
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              io_v_o       <= 1'b1;
              io_data_o    <= flit_word;
              flit_q       <= '0;
              w_state      <= W_SEND;
            end
          end
        end
        W_SEND: begin
          if (io_ready_and_i) begin
            if (flit_q == last_flit) begin
              io_v_o       <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= wid_q;
              s_axi_bresp  <= (len_q == 8'd0) ? 2'b00 : 2'b10;
              w_state      <= W_RESP;
            end else begin
              flit_q    <= flit_q + 3'd1;
              io_data_o <= flit_word;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rlast   <= 1'b0;
      rcnt_q        <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            rcnt_q        <= s_axi_arlen;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              rcnt_q      <= rcnt_q - 8'd1;
              s_axi_rlast <= (rcnt_q == 8'd1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi_rdata = '0;
  assign s_axi_rresp = 2'b00;

  wire unused = &{1'b0, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                  s_axi_awprot, s_axi_awqos, s_axi_awregion,
                  s_axi_wstrb, s_axi_araddr, s_axi_arsize,
                  s_axi_arburst, s_axi_arlock, s_axi_arcache,
                  s_axi_arprot, s_axi_arqos, s_axi_arregion};

endmodule
